// File: rtl/lieat_general_pipebuf.sv
// rtl/lieat_general_pipebuf.sv - elastic DEPTH-entry pipeline buffer with byte-masked writes
// Registered ready/valid on both sides, synchronous flush, occupancy count.
module lieat_general_pipebuf #(
  parameter int            DW        = 32,
  parameter int            DEPTH     = 2,
  parameter logic [DW-1:0] RESET_VAL = {DW{1'b0}},
  localparam int           CW        = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [DW-1:0]   i_data,
  input  logic [DW/8-1:0] i_mask,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [DW-1:0]   o_data,
  output logic [CW-1:0]   count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            NB   = DW / 8;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]    sync_q;
  logic          rst_int;
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          i_ready_q;
  logic          o_valid_q;
  logic [DW-1:0] base_q, base_d;
  logic [DW-1:0] merged;
  logic          push;
  logic          pop;

  assign rst_int = ~sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign push = i_valid & i_ready_q & ~flush;
  assign pop  = o_valid_q & o_ready & ~flush;

  // Unmasked bytes inherit from the previously pushed word.
  always_comb begin
    merged = base_q;
    for (int k = 0; k < NB; k++) begin
      if (i_mask[k]) merged[8*k +: 8] = i_data[8*k +: 8];
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    base_d   = base_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      base_d   = RESET_VAL;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        base_d   = merged;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= RESET_VAL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      i_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      base_q    <= RESET_VAL;
    end else if (rst_int) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= RESET_VAL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      // Ready rises on the same edge that releases rst_int.
      i_ready_q <= sync_q[0];
      o_valid_q <= 1'b0;
      base_q    <= RESET_VAL;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (push && wr_ptr_q == PW'(e)) mem_q[e] <= merged;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      i_ready_q <= (count_d != FULL);
      o_valid_q <= (count_d != '0);
      base_q    <= base_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_data  = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: tb/tb_lieat_general_pipebuf.sv
// tb/tb_lieat_general_pipebuf.sv - scoreboard bench for lieat_general_pipebuf
// Driver records accepted pushes in a queue; a negedge monitor pops and compares.
module tb_lieat_general_pipebuf;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock;
  logic          reset;
  logic          flush;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic [3:0]    i_mask;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] count;

  logic          clk_en;
  int            n_tests;
  int            n_fail;
  logic [31:0]   exp_q[$];
  logic [31:0]   base_m;

  lieat_general_pipebuf #(.DW(DW), .DEPTH(DEPTH), .RESET_VAL(32'h0)) dut (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_data (i_data),
    .i_mask (i_mask),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .count  (count)
  );

  always begin
    #5;
    if (clk_en) clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: a pop happens at the next posedge when o_valid & o_ready & ~flush.
  always @(negedge clock) begin
    if (reset && !flush && o_valid && o_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%08h, expected no output", o_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%08h, expected 0x%08h", o_data, e);
        end
      end
    end
  end

  task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] m,
                       input logic ordy, input logic fl);
    logic [31:0] mg;
    i_valid = v;
    i_data  = d;
    i_mask  = m;
    o_ready = ordy;
    flush   = fl;
    @(negedge clock);
    if (fl) begin
      exp_q.delete();
      base_m = 32'h0;
    end else if (v && i_ready) begin
      mg = base_m;
      for (int k = 0; k < 4; k++) if (m[k]) mg[8*k +: 8] = d[8*k +: 8];
      exp_q.push_back(mg);
      base_m = mg;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (count != 0 && n < 20) begin
      cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      n++;
    end
    check({name, "_drained"}, 32'(count), 32'd0);
    check({name, "_ovalid0"}, 32'(o_valid), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    o_ready = 1'b0;
  endtask

  task automatic release_reset(input string name);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check({name, "_iready_edge1"}, 32'(i_ready), 32'd0);
    @(posedge clock);
    #1;
    check({name, "_iready_edge2"}, 32'(i_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    base_m  = 32'h0;
    clock   = 1'b0;
    clk_en  = 1'b0;
    reset   = 1'b1;
    flush   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_mask  = '0;
    o_ready = 1'b0;

    // Reset with no clock running
    #2 reset = 1'b0;
    #3;
    check("rst_iready", 32'(i_ready), 32'd0);
    check("rst_ovalid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_odata", o_data, 32'h0);
    clk_en = 1'b1;
    release_reset("rel");

    // Fill to DEPTH with o_ready low
    cycle(1'b1, 32'h11111111, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'h22222222, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'h33333333, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'h44444444, 4'hF, 1'b0, 1'b0);
    check("fill_count4", 32'(count), 32'd4);
    check("fill_iready0", 32'(i_ready), 32'd0);
    check("fill_head", o_data, 32'h11111111);
    cycle(1'b1, 32'h55555555, 4'hF, 1'b0, 1'b0);
    check("fill_refused", 32'(count), 32'd4);
    drain("fill");

    // Simultaneous push/pop at count 2, then pop at full
    cycle(1'b1, 32'hA1A1A1A1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2A2A2A2, 4'hF, 1'b0, 1'b0);
    check("pp_count2", 32'(count), 32'd2);
    cycle(1'b1, 32'hA3A3A3A3, 4'hF, 1'b1, 1'b0);
    check("pp_count_stays2", 32'(count), 32'd2);
    check("pp_head", o_data, 32'hA2A2A2A2);
    cycle(1'b1, 32'hA4A4A4A4, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0);
    check("pp_full", 32'(count), 32'd4);
    cycle(1'b1, 32'hA6A6A6A6, 4'hF, 1'b1, 1'b0);
    check("pp_full_pop_count3", 32'(count), 32'd3);
    drain("pp");

    // Byte-mask merge
    cycle(1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'h00001122, 4'h3, 1'b0, 1'b0);
    check("mask_head", o_data, 32'hAABBCCDD);
    cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    check("mask_merged", o_data, 32'hAABB1122);
    drain("mask");

    // Flush with 3 entries and a push in the flush cycle
    cycle(1'b1, 32'hC1C1C1C1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'hC2C2C2C2, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'hC3C3C3C3, 4'hF, 1'b0, 1'b0);
    check("flush_pre_count", 32'(count), 32'd3);
    cycle(1'b1, 32'h99999999, 4'hF, 1'b0, 1'b1);
    check("flush_count0", 32'(count), 32'd0);
    check("flush_ovalid0", 32'(o_valid), 32'd0);
    check("flush_iready1", 32'(i_ready), 32'd1);
    cycle(1'b1, 32'h000000EE, 4'h1, 1'b0, 1'b0);
    check("flush_post_ovalid", 32'(o_valid), 32'd1);
    check("flush_post_data", o_data, 32'h000000EE);
    check("flush_post_count", 32'(count), 32'd1);
    drain("flush");

    // Reset in the middle of a burst
    cycle(1'b1, 32'hD1D1D1D1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'hD2D2D2D2, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'hD3D3D3D3, 4'hF, 1'b0, 1'b0);
    i_valid = 1'b0;
    #2 reset = 1'b0;
    exp_q.delete();
    base_m = 32'h0;
    #1;
    check("mid_rst_ovalid", 32'(o_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    release_reset("mid");
    cycle(1'b1, 32'h12345678, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'h9ABCDEF0, 4'hF, 1'b0, 1'b0);
    check("mid_first_head", o_data, 32'h12345678);
    check("mid_count2", 32'(count), 32'd2);
    drain("mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
